// File: rtl/game_controller_levels_if.sv
// Event inputs and status outputs exchanged between the game controller and its surroundings.
// The master side drives detector/keypad events; the slave side is the controller.
interface game_controller_levels_if #(
    parameter int unsigned SCORE_W = 4,
    parameter int unsigned LIFE_W  = 3,
    parameter int unsigned LEVEL_W = 2
) ();
    logic               start_game;
    logic               pause_key;
    logic               explosion;
    logic               wall_destroyed;
    logic               collision_bomber_enemy;
    logic               collision_bomber_mine;
    logic               timer_expired;

    logic [SCORE_W-1:0] level_score;
    logic [SCORE_W-1:0] total_score;
    logic [LIFE_W-1:0]  lives;
    logic [LEVEL_W-1:0] level;
    logic               invulnerable;
    logic               game_active;
    logic               paused;
    logic               level_reload;
    logic               explosion_sound;
    logic               hit_sound;
    logic               enable_WIN;
    logic               enable_LOSER;

    modport master (
        output start_game, pause_key, explosion, wall_destroyed,
               collision_bomber_enemy, collision_bomber_mine, timer_expired,
        input  level_score, total_score, lives, level, invulnerable, game_active,
               paused, level_reload, explosion_sound, hit_sound, enable_WIN, enable_LOSER
    );

    modport slave (
        input  start_game, pause_key, explosion, wall_destroyed,
               collision_bomber_enemy, collision_bomber_mine, timer_expired,
        output level_score, total_score, lives, level, invulnerable, game_active,
               paused, level_reload, explosion_sound, hit_sound, enable_WIN, enable_LOSER
    );
endinterface

// File: rtl/game_controller_levels.sv
// Multi-level game controller: score, lives, level, invulnerability window,
// pause, level-clear intermission and win/lose terminal states.
module game_controller_levels #(
    parameter int unsigned SCORE_W       = 4,
    parameter int unsigned LIFE_W        = 3,
    parameter int unsigned LEVEL_W       = 2,
    parameter int unsigned INITIAL_LIVES = 4,
    parameter int unsigned WIN_SCORE     = 9,
    parameter int unsigned NUM_LEVELS    = 3,
    parameter int unsigned INVULN_CYCLES = 25000000,
    parameter int unsigned CLEAR_CYCLES  = 50000000
) (
    input  logic                     clk,
    input  logic                     reset,
    game_controller_levels_if.slave  bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PLAY   = 3'd1;
    localparam logic [2:0] S_INVULN = 3'd2;
    localparam logic [2:0] S_PAUSED = 3'd3;
    localparam logic [2:0] S_CLEAR  = 3'd4;
    localparam logic [2:0] S_WIN    = 3'd5;
    localparam logic [2:0] S_LOSE   = 3'd6;

    // One shared down-counter serves both the invulnerability and intermission windows.
    localparam int unsigned CNT_MAX = (INVULN_CYCLES > CLEAR_CYCLES) ? INVULN_CYCLES : CLEAR_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [SCORE_W-1:0] SCORE_MAX   = '1;
    localparam logic [SCORE_W-1:0] WIN_LS      = SCORE_W'(WIN_SCORE);
    localparam logic [LEVEL_W-1:0] LAST_LEVEL  = LEVEL_W'(NUM_LEVELS - 1);
    localparam logic [LIFE_W-1:0]  START_LIVES = LIFE_W'(INITIAL_LIVES);
    localparam logic [CNT_W-1:0]   INVULN_LOAD = CNT_W'(INVULN_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CLEAR_LOAD  = CNT_W'(CLEAR_CYCLES - 1);

    logic [2:0]         state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [SCORE_W-1:0] level_score_q, level_score_d;
    logic [SCORE_W-1:0] total_score_q, total_score_d;
    logic [LIFE_W-1:0]  lives_q, lives_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               expl_q;
    logic               reload_q, reload_d;
    logic               expl_snd_q, expl_snd_d;
    logic               hit_snd_q, hit_snd_d;
    logic               invuln_q, invuln_d;
    logic               active_q, active_d;
    logic               paused_q, paused_d;
    logic               win_q, win_d;
    logic               lose_q, lose_d;
    logic [SCORE_W-1:0] level_score_inc;
    logic [SCORE_W-1:0] total_score_inc;
    logic               in_game;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == SCORE_MAX) ? v : v + SCORE_W'(1);
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            level_score_q <= '0;
            total_score_q <= '0;
            lives_q       <= START_LIVES;
            level_q       <= '0;
            expl_q        <= 1'b0;
            reload_q      <= 1'b0;
            expl_snd_q    <= 1'b0;
            hit_snd_q     <= 1'b0;
            invuln_q      <= 1'b0;
            active_q      <= 1'b0;
            paused_q      <= 1'b0;
            win_q         <= 1'b0;
            lose_q        <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            level_score_q <= level_score_d;
            total_score_q <= total_score_d;
            lives_q       <= lives_d;
            level_q       <= level_d;
            expl_q        <= bus.explosion;
            reload_q      <= reload_d;
            expl_snd_q    <= expl_snd_d;
            hit_snd_q     <= hit_snd_d;
            invuln_q      <= invuln_d;
            active_q      <= active_d;
            paused_q      <= paused_d;
            win_q         <= win_d;
            lose_q        <= lose_d;
        end
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_d         = state;
        cnt_d           = cnt;
        level_score_d   = level_score_q;
        total_score_d   = total_score_q;
        lives_d         = lives_q;
        level_d         = level_q;
        reload_d        = 1'b0;
        hit_snd_d       = 1'b0;
        level_score_inc = sat_inc(level_score_q);
        total_score_inc = sat_inc(total_score_q);
        in_game         = (state == S_PLAY) || (state == S_INVULN);
        expl_snd_d      = bus.explosion & ~expl_q & in_game;

        case (state)
            S_IDLE, S_WIN, S_LOSE: begin
                if (bus.start_game) begin
                    state_d       = S_PLAY;
                    cnt_d         = '0;
                    lives_d       = START_LIVES;
                    level_d       = '0;
                    level_score_d = '0;
                    total_score_d = '0;
                    reload_d      = 1'b1;
                end
            end
            S_PAUSED: begin
                if (bus.pause_key) state_d = S_PLAY;
            end
            S_CLEAR: begin
                if (cnt == '0) begin
                    state_d       = S_PLAY;
                    level_d       = level_q + LEVEL_W'(1);
                    level_score_d = '0;
                    reload_d      = 1'b1;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            S_PLAY, S_INVULN: begin
                // Window countdown runs first; any event below overrides the state.
                if (state == S_INVULN) begin
                    if (cnt == '0) state_d = S_PLAY;
                    else           cnt_d   = cnt - CNT_W'(1);
                end
                if (bus.collision_bomber_mine || bus.timer_expired) begin
                    state_d = S_LOSE;
                end else if (bus.collision_bomber_enemy && (state == S_PLAY)) begin
                    hit_snd_d = 1'b1;
                    lives_d   = lives_q - LIFE_W'(1);
                    if (lives_q == LIFE_W'(1)) begin
                        state_d = S_LOSE;
                    end else begin
                        state_d = S_INVULN;
                        cnt_d   = INVULN_LOAD;
                    end
                end else if (bus.wall_destroyed) begin
                    level_score_d = level_score_inc;
                    total_score_d = total_score_inc;
                    if (level_score_inc == WIN_LS) begin
                        if (level_q == LAST_LEVEL) begin
                            state_d = S_WIN;
                        end else begin
                            state_d = S_CLEAR;
                            cnt_d   = CLEAR_LOAD;
                        end
                    end
                end else if (bus.pause_key && (state == S_PLAY)) begin
                    state_d = S_PAUSED;
                end
            end
            default: state_d = S_IDLE;
        endcase

        invuln_d = (state_d == S_INVULN);
        active_d = (state_d == S_PLAY) || (state_d == S_INVULN);
        paused_d = (state_d == S_PAUSED);
        win_d    = (state_d == S_WIN);
        lose_d   = (state_d == S_LOSE);
    end

    assign bus.level_score     = level_score_q;
    assign bus.total_score     = total_score_q;
    assign bus.lives           = lives_q;
    assign bus.level           = level_q;
    assign bus.invulnerable    = invuln_q;
    assign bus.game_active     = active_q;
    assign bus.paused          = paused_q;
    assign bus.level_reload    = reload_q;
    assign bus.explosion_sound = expl_snd_q;
    assign bus.hit_sound       = hit_snd_q;
    assign bus.enable_WIN      = win_q;
    assign bus.enable_LOSER    = lose_q;

endmodule

// File: tb/tb_game_controller_levels.sv
// Self-checking bench for game_controller_levels: directed scenarios plus a
// randomized run against a cycle-level behavioural model of the game rules.
module tb_game_controller_levels;

    localparam int unsigned SCORE_W = 4;
    localparam int unsigned LIFE_W  = 3;
    localparam int unsigned LEVEL_W = 2;
    localparam int INIT_LIVES = 2;
    localparam int WIN_SC     = 2;
    localparam int NUM_LEV    = 2;
    localparam int INV_CYC    = 4;
    localparam int CLR_CYC    = 3;
    localparam int SMAX       = (1 << SCORE_W) - 1;

    typedef enum int {M_IDLE, M_PLAY, M_INV, M_PAUSE, M_CLEAR, M_WIN, M_LOSE} mst_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    mst_t m_st;
    int   m_ls, m_ts, m_lives, m_level, m_cnt;
    bit   m_prev, m_reload, m_esnd, m_hsnd;

    game_controller_levels_if #(.SCORE_W(SCORE_W), .LIFE_W(LIFE_W), .LEVEL_W(LEVEL_W)) bus ();

    game_controller_levels #(
        .SCORE_W(SCORE_W), .LIFE_W(LIFE_W), .LEVEL_W(LEVEL_W),
        .INITIAL_LIVES(INIT_LIVES), .WIN_SCORE(WIN_SC), .NUM_LEVELS(NUM_LEV),
        .INVULN_CYCLES(INV_CYC), .CLEAR_CYCLES(CLR_CYC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Game rules at event level; the window counter tracks cycles still to spend.
    task automatic model_step();
        mst_t cur;
        if (reset) begin
            m_st = M_IDLE; m_ls = 0; m_ts = 0; m_lives = INIT_LIVES; m_level = 0; m_cnt = 0;
            m_prev = 0; m_reload = 0; m_esnd = 0; m_hsnd = 0;
            return;
        end
        cur = m_st; m_reload = 0; m_hsnd = 0;
        m_esnd = (cur == M_PLAY || cur == M_INV) && bus.explosion && !m_prev;
        m_prev = bus.explosion;
        case (cur)
            M_IDLE, M_WIN, M_LOSE: if (bus.start_game) begin
                m_st = M_PLAY; m_lives = INIT_LIVES; m_level = 0; m_ls = 0; m_ts = 0; m_reload = 1;
            end
            M_PAUSE: if (bus.pause_key) m_st = M_PLAY;
            M_CLEAR: begin
                m_cnt--;
                if (m_cnt == 0) begin m_level++; m_ls = 0; m_reload = 1; m_st = M_PLAY; end
            end
            default: begin
                if (cur == M_INV) begin m_cnt--; if (m_cnt == 0) m_st = M_PLAY; end
                if (bus.collision_bomber_mine || bus.timer_expired) m_st = M_LOSE;
                else if (bus.collision_bomber_enemy && cur == M_PLAY) begin
                    m_hsnd = 1; m_lives--;
                    if (m_lives == 0) m_st = M_LOSE;
                    else begin m_st = M_INV; m_cnt = INV_CYC; end
                end else if (bus.wall_destroyed) begin
                    m_ls = (m_ls + 1 > SMAX) ? SMAX : m_ls + 1;
                    m_ts = (m_ts + 1 > SMAX) ? SMAX : m_ts + 1;
                    if (m_ls == WIN_SC) begin
                        if (m_level == NUM_LEV - 1) m_st = M_WIN;
                        else begin m_st = M_CLEAR; m_cnt = CLR_CYC; end
                    end
                end else if (bus.pause_key && cur == M_PLAY) m_st = M_PAUSE;
            end
        endcase
    endtask

    task automatic clear_inputs();
        bus.start_game = 0; bus.pause_key = 0; bus.explosion = 0; bus.wall_destroyed = 0;
        bus.collision_bomber_enemy = 0; bus.collision_bomber_mine = 0; bus.timer_expired = 0;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs(); reset = 1; step(); reset = 0;
    endtask

    task automatic start();
        bus.start_game = 1; step(); bus.start_game = 0;
    endtask

    task automatic test_reset();
        clear_inputs(); reset = 1; step(); step(); reset = 0; step();
        n_cmp++; if (bus.lives !== 3'd2) begin n_bad++; $display("FAIL reset_lives got=%0d exp=2", bus.lives); end
        n_cmp++; if (bus.level_score !== 4'd0) begin n_bad++; $display("FAIL reset_level_score got=%0d exp=0", bus.level_score); end
        n_cmp++; if (bus.total_score !== 4'd0) begin n_bad++; $display("FAIL reset_total_score got=%0d exp=0", bus.total_score); end
        n_cmp++; if (bus.level !== 2'd0) begin n_bad++; $display("FAIL reset_level got=%0d exp=0", bus.level); end
        n_cmp++; if ({bus.game_active, bus.paused, bus.invulnerable, bus.enable_WIN, bus.enable_LOSER} !== 5'b0)
            begin n_bad++; $display("FAIL reset_flags got=%b exp=00000", {bus.game_active, bus.paused, bus.invulnerable, bus.enable_WIN, bus.enable_LOSER}); end
        n_cmp++; if ({bus.level_reload, bus.explosion_sound, bus.hit_sound} !== 3'b0)
            begin n_bad++; $display("FAIL reset_pulses got=%b exp=000", {bus.level_reload, bus.explosion_sound, bus.hit_sound}); end
    endtask

    task automatic test_level_progress();
        int k;
        do_reset(); start();
        n_cmp++; if (bus.level_reload !== 1'b1 || bus.game_active !== 1'b1) begin n_bad++; $display("FAIL start_reload got=%b%b exp=11", bus.level_reload, bus.game_active); end
        bus.wall_destroyed = 1; step(); step(); bus.wall_destroyed = 0;
        n_cmp++; if (bus.game_active !== 1'b0 || bus.level_score !== 4'd2) begin n_bad++; $display("FAIL clear_entry active=%b ls=%0d exp active=0 ls=2", bus.game_active, bus.level_score); end
        k = 0;
        for (int i = 1; i <= 8; i++) begin step(); if (bus.level_reload === 1'b1) begin k = i; break; end end
        n_cmp++; if (k != 3) begin n_bad++; $display("FAIL clear_latency got=%0d exp=3", k); end
        n_cmp++; if (bus.level !== 2'd1 || bus.level_score !== 4'd0 || bus.total_score !== 4'd2 || bus.game_active !== 1'b1)
            begin n_bad++; $display("FAIL next_level lvl=%0d ls=%0d ts=%0d act=%b exp 1 0 2 1", bus.level, bus.level_score, bus.total_score, bus.game_active); end
        step();
        n_cmp++; if (bus.level_reload !== 1'b0) begin n_bad++; $display("FAIL reload_width got=%b exp=0", bus.level_reload); end
        bus.wall_destroyed = 1; step(); step(); bus.wall_destroyed = 0;
        n_cmp++; if (bus.enable_WIN !== 1'b1 || bus.total_score !== 4'd4 || bus.game_active !== 1'b0)
            begin n_bad++; $display("FAIL win win=%b ts=%0d act=%b exp 1 4 0", bus.enable_WIN, bus.total_score, bus.game_active); end
    endtask

    task automatic test_invuln();
        int inv_cnt, hits;
        do_reset(); start();
        bus.collision_bomber_enemy = 1; step(); bus.collision_bomber_enemy = 0;
        n_cmp++; if (bus.lives !== 3'd1 || bus.hit_sound !== 1'b1 || bus.invulnerable !== 1'b1)
            begin n_bad++; $display("FAIL first_hit lives=%0d hs=%b inv=%b exp 1 1 1", bus.lives, bus.hit_sound, bus.invulnerable); end
        inv_cnt = 1; hits = 0;
        for (int i = 1; i <= 8; i++) begin
            bus.collision_bomber_enemy = (i == 1);
            step();
            if (bus.invulnerable === 1'b1) inv_cnt++;
            if (bus.hit_sound === 1'b1) hits++;
        end
        bus.collision_bomber_enemy = 0;
        n_cmp++; if (inv_cnt != 4) begin n_bad++; $display("FAIL invuln_len got=%0d exp=4", inv_cnt); end
        n_cmp++; if (hits != 0 || bus.lives !== 3'd1 || bus.game_active !== 1'b1)
            begin n_bad++; $display("FAIL hit_in_window hits=%0d lives=%0d act=%b exp 0 1 1", hits, bus.lives, bus.game_active); end
        bus.collision_bomber_enemy = 1; step(); bus.collision_bomber_enemy = 0;
        n_cmp++; if (bus.lives !== 3'd0 || bus.enable_LOSER !== 1'b1 || bus.hit_sound !== 1'b1)
            begin n_bad++; $display("FAIL last_life lives=%0d lose=%b hs=%b exp 0 1 1", bus.lives, bus.enable_LOSER, bus.hit_sound); end
    endtask

    task automatic test_mine_wall();
        do_reset(); start();
        bus.wall_destroyed = 1; step();
        bus.collision_bomber_mine = 1; step(); clear_inputs();
        n_cmp++; if (bus.enable_LOSER !== 1'b1 || bus.level_score !== 4'd1 || bus.total_score !== 4'd1)
            begin n_bad++; $display("FAIL mine_wall lose=%b ls=%0d ts=%0d exp 1 1 1", bus.enable_LOSER, bus.level_score, bus.total_score); end
    endtask

    task automatic test_pause();
        do_reset(); start();
        bus.wall_destroyed = 1; step(); bus.wall_destroyed = 0;
        bus.pause_key = 1; step(); bus.pause_key = 0;
        n_cmp++; if (bus.paused !== 1'b1 || bus.game_active !== 1'b0) begin n_bad++; $display("FAIL pause_enter p=%b act=%b exp 1 0", bus.paused, bus.game_active); end
        for (int i = 0; i < 4; i++) begin
            bus.wall_destroyed = (i == 0); bus.collision_bomber_enemy = (i == 1);
            bus.timer_expired = (i == 2); bus.collision_bomber_mine = (i == 3);
            step();
        end
        clear_inputs();
        n_cmp++; if (bus.paused !== 1'b1 || bus.level_score !== 4'd1 || bus.lives !== 3'd2 || bus.enable_LOSER !== 1'b0)
            begin n_bad++; $display("FAIL pause_ignore p=%b ls=%0d lives=%0d lose=%b exp 1 1 2 0", bus.paused, bus.level_score, bus.lives, bus.enable_LOSER); end
        bus.pause_key = 1; step(); bus.pause_key = 0;
        n_cmp++; if (bus.paused !== 1'b0 || bus.game_active !== 1'b1 || bus.level_score !== 4'd1 || bus.total_score !== 4'd1)
            begin n_bad++; $display("FAIL pause_exit p=%b act=%b ls=%0d ts=%0d exp 0 1 1 1", bus.paused, bus.game_active, bus.level_score, bus.total_score); end
    endtask

    task automatic test_explosion();
        int pulses;
        do_reset(); start();
        pulses = 0; bus.explosion = 1;
        for (int i = 0; i < 5; i++) begin step(); if (bus.explosion_sound === 1'b1) pulses++; end
        bus.explosion = 0; step();
        n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL expl_play got=%0d exp=1", pulses); end
        bus.pause_key = 1; step(); bus.pause_key = 0;
        pulses = 0; bus.explosion = 1;
        for (int i = 0; i < 3; i++) begin step(); if (bus.explosion_sound === 1'b1) pulses++; end
        bus.pause_key = 1; step(); bus.pause_key = 0;
        if (bus.explosion_sound === 1'b1) pulses++;
        for (int i = 0; i < 2; i++) begin step(); if (bus.explosion_sound === 1'b1) pulses++; end
        bus.explosion = 0;
        n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL expl_paused got=%0d exp=0", pulses); end
    endtask

    task automatic test_reset_mid();
        do_reset(); start();
        bus.wall_destroyed = 1; step(); step(); bus.wall_destroyed = 0; step();
        reset = 1; step(); reset = 0;
        n_cmp++; if (bus.level !== 2'd0 || bus.lives !== 3'd2 || bus.level_score !== 4'd0 || bus.total_score !== 4'd0 || bus.game_active !== 1'b0)
            begin n_bad++; $display("FAIL reset_mid lvl=%0d lives=%0d ls=%0d ts=%0d act=%b exp 0 2 0 0 0", bus.level, bus.lives, bus.level_score, bus.total_score, bus.game_active); end
        // Reach LOSE with dirty counters, then restart.
        start();
        bus.collision_bomber_enemy = 1; step(); bus.collision_bomber_enemy = 0;
        bus.wall_destroyed = 1; step(); bus.wall_destroyed = 0;
        bus.timer_expired = 1; step(); bus.timer_expired = 0;
        n_cmp++; if (bus.enable_LOSER !== 1'b1 || bus.lives !== 3'd1 || bus.level_score !== 4'd1)
            begin n_bad++; $display("FAIL timer_lose lose=%b lives=%0d ls=%0d exp 1 1 1", bus.enable_LOSER, bus.lives, bus.level_score); end
        start();
        n_cmp++; if (bus.lives !== 3'd2 || bus.level_score !== 4'd0 || bus.total_score !== 4'd0 || bus.level !== 2'd0 || bus.level_reload !== 1'b1 || bus.enable_LOSER !== 1'b0)
            begin n_bad++; $display("FAIL restart lives=%0d ls=%0d ts=%0d lvl=%0d rl=%b lose=%b exp 2 0 0 0 1 0", bus.lives, bus.level_score, bus.total_score, bus.level, bus.level_reload, bus.enable_LOSER); end
    endtask

    task automatic test_random();
        logic [11:0] got, exp;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            reset                      = ($urandom_range(0, 199) == 0);
            bus.start_game             = ($urandom_range(0, 99) < 4);
            bus.pause_key              = ($urandom_range(0, 99) < 6);
            bus.wall_destroyed         = ($urandom_range(0, 99) < 35);
            bus.collision_bomber_enemy = ($urandom_range(0, 99) < 6);
            bus.collision_bomber_mine  = ($urandom_range(0, 99) < 1);
            bus.timer_expired          = ($urandom_range(0, 99) < 1);
            if ($urandom_range(0, 99) < 25) bus.explosion = ~bus.explosion;
            step();
            n_cmp++;
            if (bus.level_score !== SCORE_W'(m_ls) || bus.total_score !== SCORE_W'(m_ts) ||
                bus.lives !== LIFE_W'(m_lives) || bus.level !== LEVEL_W'(m_level))
            begin n_bad++; $display("FAIL rand_counts cyc=%0d ls=%0d/%0d ts=%0d/%0d lives=%0d/%0d lvl=%0d/%0d (got/exp)", i, bus.level_score, m_ls, bus.total_score, m_ts, bus.lives, m_lives, bus.level, m_level); end
            got = {4'b0, bus.invulnerable, bus.game_active, bus.paused, bus.enable_WIN, bus.enable_LOSER,
                   bus.level_reload, bus.explosion_sound, bus.hit_sound};
            exp = {4'b0, m_st == M_INV, m_st == M_PLAY || m_st == M_INV, m_st == M_PAUSE, m_st == M_WIN, m_st == M_LOSE,
                   m_reload, m_esnd, m_hsnd};
            n_cmp++;
            if (got !== exp) begin n_bad++; $display("FAIL rand_flags cyc=%0d got=%b exp=%b", i, got, exp); end
        end
        reset = 0; clear_inputs();
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        reset = 1; clear_inputs();
        test_reset();
        test_level_progress();
        test_invuln();
        test_mine_wall();
        test_pause();
        test_explosion();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
